keypad_matrix_scanner: RTL and testbench

Upstream front end for the keypad/7-segment display path. The block scans a 4-row × 3-column key matrix one column at a time and debounces complete scan frames. It then delivers a clean, registered 12-bit one-hot key vector, which feeds the `iKeypad` input of the display stage directly. It also provides a one-cycle strobe for each new key press.

---
 rtl/keypad_matrix_scanner_if.sv | 11 +
 rtl/keypad_matrix_scanner.sv | 119 +++++++++++
 tb/tb_keypad_matrix_scanner.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_scanner_if.sv
// Signal bundle between the keypad matrix scanner and its surroundings.
// The master side is the scanner: it senses rows and drives columns and the debounced key vector.
interface keypad_matrix_scanner_if;
  logic [3:0]  iRow;
  logic [2:0]  oCol;
  logic [11:0] oKeypad;
  logic        oKeyPulse;

  modport master (input iRow, output oCol, output oKeypad, output oKeyPulse);
  modport slave  (output iRow, input oCol, input oKeypad, input oKeyPulse);
endinterface

// File: rtl/keypad_matrix_scanner.sv
// Scans a 4x3 key matrix one column at a time, rejects multi-key frames and
// debounces whole frames into a one-hot key vector with a press strobe.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 8
) (
  input  logic                     iCLK,
  input  logic                     nRST,
  keypad_matrix_scanner_if.master  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEB_CNT);

  typedef enum logic [1:0] {COL0, COL1, COL2} colState_t;
  typedef enum logic [1:0] {IDLE, QUALIFY, UPDATE} debState_t;

  colState_t        col, colNext;
  logic [DIV_W-1:0] div, divNext;
  logic             sampleEn;
  logic [11:0]      raw, rawNext;
  logic             rawDone;
  logic [11:0]      frame, frameFiltered;
  logic             frameDone;
  logic [11:0]      cand, candNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [11:0]      keypad, keypadNext, keypadPrev;
  logic             keyPulse;
  debState_t        debState, debStateNext;

  assign sampleEn = (div == DIV_LAST);

  // Column / dwell sequencing
  always_comb begin
    divNext = div + DIV_W'(1);
    colNext = col;
    if (sampleEn) begin
      divNext = '0;
      unique case (col)
        COL0:    colNext = COL1;
        COL1:    colNext = COL2;
        default: colNext = COL0;
      endcase
    end
  end

  // Each raw bit only listens to its own column on that column's last dwell cycle
  for (genvar gi = 0; gi < 12; gi++) begin : g_raw
    assign rawNext[gi] = (sampleEn && (col == 2'(gi % 3))) ? bus.iRow[gi / 3] : raw[gi];
  end

  // x & (x-1) is nonzero exactly when two or more bits are set
  assign frameFiltered = ((raw & (raw - 12'd1)) != 12'h000) ? 12'h000 : raw;

  always_comb begin
    candNext     = cand;
    cntNext      = cnt;
    keypadNext   = keypad;
    debStateNext = debState;
    if (frameDone) begin
      if (frame == cand) begin
        cntNext = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);
      end else begin
        candNext = frame;
        cntNext  = CNT_W'(1);
      end
      if ((cntNext == CNT_FULL) && (candNext != keypad)) begin
        keypadNext   = candNext;
        debStateNext = UPDATE;
      end else if (cntNext == CNT_FULL) begin
        debStateNext = IDLE;
      end else begin
        debStateNext = QUALIFY;
      end
    end else if (debState == UPDATE) begin
      debStateNext = IDLE;
    end
  end

  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      col        <= COL0;
      div        <= '0;
      raw        <= '0;
      rawDone    <= 1'b0;
      frame      <= '0;
      frameDone  <= 1'b0;
      cand       <= '0;
      cnt        <= '0;
      keypad     <= '0;
      keypadPrev <= '0;
      keyPulse   <= 1'b0;
      debState   <= QUALIFY;
    end else begin
      col        <= colNext;
      div        <= divNext;
      raw        <= rawNext;
      rawDone    <= sampleEn && (col == COL2);
      frameDone  <= rawDone;
      if (rawDone) begin
        frame <= frameFiltered;
      end
      cand       <= candNext;
      cnt        <= cntNext;
      keypad     <= keypadNext;
      debState   <= debStateNext;
      // Strobe lands the cycle after the vector moves to a new nonzero key
      keypadPrev <= keypad;
      keyPulse   <= (keypad != keypadPrev) && (keypad != 12'h000);
    end
  end

  assign bus.oCol      = 3'b001 << col;
  assign bus.oKeypad   = keypad;
  assign bus.oKeyPulse = keyPulse;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: stimulus queues expected key-vector
// changes, a monitor pops them whenever oKeypad moves and polices oKeyPulse.
module tb_keypad_matrix_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB_CNT  = 3;
  localparam int FRAME    = 3 * SCAN_DIV;

  typedef struct {
    logic [11:0] val;
    int          edgeNo;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [11:0] keys;
  logic [3:0]  glitch;
  logic [3:0]  rowDrive;
  int          edgeCnt = 0;
  int          chkCnt = 0;
  int          errCnt = 0;
  exp_t        expQ[$];

  always #5 clk = ~clk;

  keypad_matrix_scanner_if bus();

  keypad_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
    .iCLK (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  // Matrix model: a closed key connects its column drive to its row line
  always_comb begin
    rowDrive = '0;
    for (int r = 0; r < 4; r++) begin
      rowDrive[r] = |(keys[3*r +: 3] & bus.oCol);
    end
  end
  assign bus.iRow = rowDrive | glitch;

  // Edges counted from reset release; edge 1 is the first rising edge with nRST high
  always @(posedge clk) begin
    if (!nRST) edgeCnt <= 0;
    else       edgeCnt <= edgeCnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    chkCnt++;
    if (act !== req) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, req, $time);
    end
  endtask

  task automatic expectKey(input logic [11:0] val, input int edgeNo, input string tag);
    exp_t e;
    e.val    = val;
    e.edgeNo = edgeNo;
    e.tag    = tag;
    expQ.push_back(e);
    $display("issue  %-12s expect oKeypad=0x%03h edge=%0d", tag, val, edgeNo);
  endtask

  task automatic waitFrames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic alignFrame();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((edgeCnt % FRAME != 0) && (guard < 2 * FRAME));
  endtask

  // Monitor / scoreboard
  initial begin
    logic [11:0] prevKey;
    bit          pending;
    exp_t        e;
    prevKey = '0;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        check("pulse", {31'd0, bus.oKeyPulse}, 32'd1);
        pending = 1'b0;
      end else if (bus.oKeyPulse !== 1'b0) begin
        check("no_pulse", {31'd0, bus.oKeyPulse}, 32'd0);
      end
      if (bus.oKeypad !== prevKey) begin
        if (expQ.size() == 0) begin
          chkCnt++;
          errCnt++;
          $display("FAIL unexpected_change: got 0x%03h, expected 0x%03h held", bus.oKeypad, prevKey);
        end else begin
          e = expQ.pop_front();
          $display("observe %-12s oKeypad=0x%03h edge=%0d", e.tag, bus.oKeypad, edgeCnt);
          check({e.tag, "_val"}, {20'd0, bus.oKeypad}, {20'd0, e.val});
          if (e.edgeNo >= 0) check({e.tag, "_edge"}, edgeCnt, e.edgeNo);
        end
        if (bus.oKeypad !== 12'h000) pending = 1'b1;
        prevKey = bus.oKeypad;
      end
    end
  end

  int          colEdge[6] = '{0, 3, 4, 8, 11, 12};
  logic [2:0]  colExp[6]  = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b001};

  // Stimulus
  initial begin
    exp_t e;
    keys   = '0;
    glitch = '0;

    // Reset, run into the middle of column 1, then reset again
    repeat (3) @(negedge clk);
    @(posedge clk); #2 nRST = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk); #2 nRST = 1'b0;
    keys = 12'h001;
    repeat (2) @(negedge clk);
    check("rst_col",    {29'd0, bus.oCol}, 32'd1);
    check("rst_keypad", {20'd0, bus.oKeypad}, 32'd0);
    check("rst_pulse",  {31'd0, bus.oKeyPulse}, 32'd0);

    // Single press held from release: arrives at edge 38
    expectKey(12'h001, 38, "press_r0c0");
    @(posedge clk); #2 nRST = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      while (edgeCnt < colEdge[i]) @(negedge clk);
      check($sformatf("col_edge%0d", colEdge[i]), {29'd0, bus.oCol}, {29'd0, colExp[i]});
    end
    repeat (40) @(negedge clk);
    keys = 12'h000;
    expectKey(12'h000, -1, "release");
    waitFrames(5);

    // Key mapping
    keys = 12'h800; expectKey(12'h800, -1, "r3c2"); waitFrames(5);
    keys = 12'h400; expectKey(12'h400, -1, "r3c1"); waitFrames(5);
    keys = 12'h040; expectKey(12'h040, -1, "r2c0"); waitFrames(5);
    keys = 12'h000; expectKey(12'h000, -1, "release2"); waitFrames(5);

    // Bounce: alternate frames never qualify
    for (int i = 0; i < 10; i++) begin
      alignFrame();
      keys = (i % 2 == 0) ? 12'h002 : 12'h000;
    end
    alignFrame();
    check("bounce_hold", {20'd0, bus.oKeypad}, 32'd0);
    keys = 12'h002; expectKey(12'h002, -1, "r0c1_steady"); waitFrames(5);

    // Multi-key replaces the frame with zero
    keys = 12'h001; expectKey(12'h001, -1, "r0c0_again"); waitFrames(5);
    keys = 12'h011; expectKey(12'h000, -1, "ghost"); waitFrames(5);
    keys = 12'h000;

    // Row glitches during column-0 settling cycles only
    for (int i = 0; i < 4; i++) begin
      alignFrame();
      glitch = 4'b0001;
      do begin
        @(posedge clk); #1;
      end while (edgeCnt % SCAN_DIV != SCAN_DIV - 1);
      glitch = 4'b0000;
    end
    waitFrames(1);
    check("glitch_hold", {20'd0, bus.oKeypad}, 32'd0);

    // Reset after two qualifying frames: re-press needs three full frames
    alignFrame();
    keys = 12'h008;
    repeat (2 * FRAME + 3) @(negedge clk);
    @(posedge clk); #2 nRST = 1'b0;
    repeat (2) @(negedge clk);
    check("mq_rst_col",    {29'd0, bus.oCol}, 32'd1);
    check("mq_rst_keypad", {20'd0, bus.oKeypad}, 32'd0);
    expectKey(12'h008, 38, "repress");
    @(posedge clk); #2 nRST = 1'b1;
    waitFrames(5);

    // Reset while a key is shown clears it at once, without a strobe
    expectKey(12'h000, -1, "rst_clear");
    @(posedge clk); #2 nRST = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_clear_now", {20'd0, bus.oKeypad}, 32'd0);
    keys = 12'h000;
    @(posedge clk); #2 nRST = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 100 && expQ.size() > 0; i++) @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      chkCnt++;
      errCnt++;
      $display("FAIL %s_missing: got no change, expected oKeypad=0x%03h", e.tag, e.val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chkCnt, errCnt);
    $finish;
  end

endmodule
